// File: rtl/oka163_mul_arbiter.sv
// -----------------------------------------------------------------------------
// oka163_mul_arbiter
//
// Shares a single combinational 163-bit Karatsuba carry-less multiplier
// (OKA_163bit) between two requesters. A round-robin arbiter grants one
// request at a time. The granted operands are registered and held stable
// for MUL_CYCLES cycles (a multicycle path through the multiplier). Then the
// unreduced 325-bit product is captured and offered with the requester ID
// on a valid/ready response channel.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 synchronous active-high reset
//   req0_valid/ready    requester 0 handshake (ready is combinational)
//   req0_a, req0_b      requester 0 operands (163 bits, sampled on handshake)
//   req1_*              same for requester 1
//   rsp_valid/ready     response handshake
//   rsp_data            325-bit carry-less product a*b (no reduction)
//   rsp_id              requester that issued the operation
//   busy                high whenever the FSM is not idle
// -----------------------------------------------------------------------------

// Schoolbook carry-less multiplier, W x W -> 2W-1 bits.
// Inputs: x_i, y_i (W bits). Output: p_o (2W-1 bits).
module oka_clmul #(
  parameter int W = 82
) (
  input  logic [W-1:0]   x_i,
  input  logic [W-1:0]   y_i,
  output logic [2*W-2:0] p_o
);
  logic [2*W-2:0] pp [W];

  // One shifted partial product per multiplier bit, XOR-accumulated below.
  for (genvar gi = 0; gi < W; gi++) begin : g_pp
    assign pp[gi] = y_i[gi] ? ({{(W-1){1'b0}}, x_i} << gi) : '0;
  end

  always_comb begin
    p_o = '0;
    for (int i = 0; i < W; i++) begin
      p_o = p_o ^ pp[i];
    end
  end
endmodule

// One-level Karatsuba over GF(2)[x] for 163-bit operands.
// Inputs: a_i, b_i (163 bits). Output: c_o (325-bit unreduced product).
// Split is 82 low bits plus 81 high bits:
//   a*b = ah*bh*x^164 + ((al^ah)(bl^bh) ^ al*bl ^ ah*bh)*x^82 + al*bl
module OKA_163bit (
  input  logic [162:0] a_i,
  input  logic [162:0] b_i,
  output logic [324:0] c_o
);
  logic [81:0]  al, bl, am, bm;
  logic [80:0]  ah, bh;
  logic [162:0] p_lo, p_mx, p_mid;
  logic [160:0] p_hi;

  assign al = a_i[81:0];
  assign bl = b_i[81:0];
  assign ah = a_i[162:82];
  assign bh = b_i[162:82];
  assign am = al ^ {1'b0, ah};
  assign bm = bl ^ {1'b0, bh};

  oka_clmul #(.W(82)) u_lo  (.x_i(al), .y_i(bl), .p_o(p_lo));
  oka_clmul #(.W(81)) u_hi  (.x_i(ah), .y_i(bh), .p_o(p_hi));
  oka_clmul #(.W(82)) u_mid (.x_i(am), .y_i(bm), .p_o(p_mx));

  assign p_mid = p_mx ^ p_lo ^ {2'b00, p_hi};

  assign c_o = {p_hi, 164'b0}
             ^ {80'b0, p_mid, 82'b0}
             ^ {162'b0, p_lo};
endmodule

module oka163_mul_arbiter #(
  parameter int unsigned MUL_CYCLES = 2  // legal 1..15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [162:0] req0_a,
  input  logic [162:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [162:0] req1_a,
  input  logic [162:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [324:0] rsp_data,
  output logic         rsp_id,
  output logic         busy
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic [162:0]   a_q, b_q;
  logic           id_q;
  logic           last_grant_q;
  logic           rsp_valid_q;
  logic           rsp_id_q;
  logic [324:0]   rsp_data_q;
  logic           busy_q;
  logic [324:0]   prod;
  logic           grant0, grant1;

  // Multiplier sees only the operand registers, so its inputs are quiet for
  // the whole multicycle window.
  OKA_163bit u_mul (.a_i(a_q), .b_i(b_q), .c_o(prod));

  // Round-robin: on a tie the requester that was not granted last wins.
  // Grants are suppressed during reset so ready never glitches high then.
  assign grant0 = (state_q == S_IDLE) && !rst && req0_valid &&
                  (!req1_valid || last_grant_q);
  assign grant1 = (state_q == S_IDLE) && !rst && req1_valid &&
                  (!req0_valid || !last_grant_q);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant0 || grant1) begin
            a_q          <= grant1 ? req1_a : req0_a;
            b_q          <= grant1 ? req1_b : req0_b;
            id_q         <= grant1;
            last_grant_q <= grant1;
            cnt_q        <= CNT_INIT;
            busy_q       <= 1'b1;
            state_q      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= prod;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          // Returning to IDLE here means the earliest new grant is the
          // following cycle, never the acceptance cycle itself.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_oka163_mul_arbiter.sv
module tb_oka163_mul_arbiter;
  localparam int MC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [162:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [324:0] rsp_data;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  oka163_mul_arbiter #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  task automatic check(input string tag, input logic [324:0] got,
                       input logic [324:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bitwise carry-less reference model.
  function automatic logic [324:0] clmul(input logic [162:0] a,
                                         input logic [162:0] b);
    logic [324:0] r;
    r = '0;
    for (int i = 0; i < 163; i++)
      if (b[i]) r = r ^ ({162'b0, a} << i);
    return r;
  endfunction

  function automatic logic [162:0] rand163();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[162:0];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    check("rst_rdy0", 325'(req0_ready), 325'(0));
    check("rst_rdy1", 325'(req1_ready), 325'(0));
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rst_busy", 325'(busy), 325'(0));
    check("rst_valid", 325'(rsp_valid), 325'(0));
    check("rst_data", rsp_data, '0);
    check("rst_id", 325'(rsp_id), 325'(0));
  endtask

  // Issue one operation from the current (idle) cycle and consume the result.
  task automatic run_op(input string tag, input logic v0, input logic v1,
                        input logic [162:0] a0, input logic [162:0] b0,
                        input logic [162:0] a1, input logic [162:0] b1,
                        input logic exp_id, input logic [324:0] exp_data,
                        input int bp);
    int lat;
    logic [324:0] held;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    rsp_ready = (bp == 0);
    #1;
    check({tag, "/rdy0"}, 325'(req0_ready), 325'(!exp_id));
    check({tag, "/rdy1"}, 325'(req1_ready), 325'(exp_id));
    tick();  // cycle 1
    // Operands are don't-care after the handshake; scramble them.
    req0_a = rand163(); req0_b = rand163();
    req1_a = rand163(); req1_b = rand163();
    check({tag, "/busy"}, 325'(busy), 325'(1));
    check({tag, "/busy_rdy"}, 325'(req0_ready | req1_ready), 325'(0));
    lat = 1;
    while (!rsp_valid && lat < MC + 10) begin
      tick();
      lat++;
    end
    check({tag, "/latency"}, 325'(lat), 325'(MC + 1));
    check({tag, "/data"}, rsp_data, exp_data);
    check({tag, "/id"}, 325'(rsp_id), 325'(exp_id));
    held = rsp_data;
    for (int i = 0; i < bp; i++) begin
      tick();
      check({tag, "/bp_valid"}, 325'(rsp_valid), 325'(1));
      check({tag, "/bp_data"}, rsp_data, held);
      check({tag, "/bp_id"}, 325'(rsp_id), 325'(exp_id));
      check({tag, "/bp_rdy"}, 325'(req0_ready | req1_ready), 325'(0));
    end
    rsp_ready = 1'b1;
    #1;
    check({tag, "/acc_rdy"}, 325'(req0_ready | req1_ready), 325'(0));
    tick();
    check({tag, "/idle_valid"}, 325'(rsp_valid), 325'(0));
    check({tag, "/idle_busy"}, 325'(busy), 325'(0));
    if (v0 && v1)
      check({tag, "/regrant"}, 325'(req0_ready | req1_ready), 325'(1));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    $display("[TB] op %s id=%0d lat=%0d bp=%0d", tag, exp_id, lat, bp);
  endtask

  initial begin
    logic [162:0] ones, msb, x0, y0, x1, y1;
    logic         exp_id;
    int           n;
    ones = '1;
    msb = 163'b1 << 162;
    rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    do_reset();

    run_op("single", 1'b1, 1'b0, 163'd3, 163'd3, '0, '0, 1'b0, 325'd5, 0);
    run_op("msb", 1'b0, 1'b1, '0, '0, msb, msb, 1'b1, 325'b1 << 324, 0);
    run_op("ones", 1'b1, 1'b0, ones, 163'd1, '0, '0, 1'b0,
           {162'b0, ones}, 0);

    // Tie fairness after reset: 0,1,0,1,0,1.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      x0 = rand163(); y0 = rand163(); x1 = rand163(); y1 = rand163();
      exp_id = k[0];
      run_op($sformatf("tie%0d", k), 1'b1, 1'b1, x0, y0, x1, y1, exp_id,
             exp_id ? clmul(x1, y1) : clmul(x0, y0), 0);
    end

    // Backpressure, both valid, last grant was 1 so requester 0 wins.
    x0 = rand163(); y0 = rand163(); x1 = rand163(); y1 = rand163();
    run_op("bp", 1'b1, 1'b1, x0, y0, x1, y1, 1'b0, clmul(x0, y0), 5);

    // Reset in BUSY (cycle 1).
    req0_valid = 1'b1; req0_a = 163'd7; req0_b = 163'd9;
    #1;
    check("rb/rdy0", 325'(req0_ready), 325'(1));
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rb/busy", 325'(busy), 325'(0));
    for (int i = 0; i < MC + 3; i++) begin
      check("rb/no_valid", 325'(rsp_valid), 325'(0));
      tick();
    end
    x0 = rand163(); y0 = rand163(); x1 = rand163(); y1 = rand163();
    run_op("post_rb", 1'b1, 1'b1, x0, y0, x1, y1, 1'b0, clmul(x0, y0), 0);

    // Reset in DONE: last grant is now 0, so a tie would go to 1 without it.
    req0_valid = 1'b1; req0_a = 163'd5; req0_b = 163'd3;
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < MC + 10) begin
      tick();
      n++;
    end
    check("rd/reached_done", 325'(rsp_valid), 325'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    check("rd/valid", 325'(rsp_valid), 325'(0));
    check("rd/data", rsp_data, '0);
    check("rd/busy", 325'(busy), 325'(0));
    x0 = rand163(); y0 = rand163(); x1 = rand163(); y1 = rand163();
    run_op("post_rd", 1'b1, 1'b1, x0, y0, x1, y1, 1'b0, clmul(x0, y0), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/oka163_mul_arbiter.md
# oka163_mul_arbiter

Shares one combinational `OKA_163bit` Karatsuba multiplier between two requesters. It performs round-robin arbitration, registers the granted operands, and holds them stable across a fixed multicycle window. It then captures the 325-bit GF(2)[x] product and returns it with the requester ID over a valid/ready response channel. It sits between the point-arithmetic sequencers and the multiplier, and is the only instantiation point for `OKA_163bit` in the field-arithmetic layer.

## Interface
Parameters:
- `MUL_CYCLES`, default 2: number of cycles the operands are held before the product is sampled (multicycle path budget). Legal range 1..15.

Ports:
- `clk` in 1: single clock; everything is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 granted; handshake when `req0_valid && req0_ready`.
- `req0_a`, `req0_b` in 163 each: requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as above, for requester 1.
- `rsp_valid` out 1: product available.
- `rsp_ready` in 1: consumer accepts the product.
- `rsp_data` out 325: carry-less product a·b.
- `rsp_id` out 1: requester that issued the operation.
- `busy` out 1: high in every state except IDLE.

## Operation
- One internal `OKA_163bit` instance.
  - Its inputs are driven only from the operand registers `a_q`/`b_q`, never directly from ports.
- State machine: IDLE, BUSY, DONE.
- IDLE:
  - `reqN_ready` is combinational and asserted only for the arbitration winner.
  - With a single `valid`, that requester wins.
  - When both are valid, the requester not equal to `last_grant` wins.
  - On handshake: latch `a_q`/`b_q` and `id_q`, set `last_grant` to the winner, load counter = `MUL_CYCLES`-1, and go to BUSY.
  - With no valid, stay in IDLE.
- BUSY:
  - Both `ready` are low.
  - The counter decrements each cycle.
  - In the cycle the counter is 0: capture the multiplier output into `rsp_data`, set `rsp_valid`, and go to DONE.
- DONE:
  - `rsp_valid` is high; `rsp_data` and `rsp_id` are held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - A new grant cannot occur in the same cycle as response acceptance.
- Width rule: `rsp_data` holds the full unreduced 325-bit product. Bits [324:0] are always defined, and bit 324 is set only when both operand MSBs are set. Modular reduction is the consumer's job.
- Operand ports are don't-care outside the handshake cycle.

## Timing
- Reset values:
  - state = IDLE, `busy` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
  - `a_q` = `b_q` = 0, counter = 0.
  - Both `ready` outputs are 0 while `rst` is high.
- Latency, counting the handshake cycle as cycle 0:
  - BUSY occupies cycles 1..`MUL_CYCLES`.
  - `rsp_valid` rises in cycle `MUL_CYCLES`+1 (cycle 3 with the default).
- Throughput with `rsp_ready` tied high: one operation every `MUL_CYCLES`+2 cycles. The earliest next grant is the cycle after response acceptance.
- `a_q`/`b_q` stay constant from cycle 1 through the capture edge. This is the declared multicycle path; the constraint is `MUL_CYCLES` setup and `MUL_CYCLES`-1 hold.
- Backpressure: while `rsp_ready` is low in DONE, nothing changes and no requester is granted, regardless of the request inputs.
- Request withdrawal: a `valid` dropped before its handshake is legal; no state changes.
- Reset mid-operation, in BUSY or DONE: return to IDLE next cycle with all reset values. The in-flight product is discarded and never presented.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

## Test plan
- Single op: `req0_a`=3, `req0_b`=3 → `rsp_valid` in cycle 3 with `rsp_data`=5 and `rsp_id`=0.
- MSB corner: `req1_a`=`req1_b`=1<<162 → `rsp_data`=1<<324, `rsp_id`=1. Also a=all-ones(163), b=1 → `rsp_data`=all-ones in the low 163 bits.
- Tie after reset: both valid with distinct operands → grants 0 then 1, alternating over 6 operations. Each `rsp_id` matches its operands, and each product matches the bench's bitwise carry-less model.
- Backpressure: hold `rsp_ready` low for 5 cycles in DONE with both requests valid → `rsp_data`/`rsp_id` stable, `req*_ready`=0, and no grant until one cycle after acceptance.
- Reset in BUSY (cycle 1) and in DONE → `rsp_valid` never asserts for that operation. The next grant goes to requester 0 with correct results.
- `MUL_CYCLES`=1 and 4 builds → `rsp_valid` rises in cycle 2 and cycle 5 respectively, with the same products as above.
